// File: rtl/if_stage_pkg.sv
// Shared types for the instruction-fetch stage: next-PC select codes,
// fetch FSM states and the {pc+4, instruction} word pair.
package if_stage_pkg;

    // Next-PC select codes driven by the decode stage.
    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_BR  = 2'b01,
        PC_JR  = 2'b10,
        PC_J   = 2'b11
    } pcsel_t;

    // Fetch FSM: requesting, holding an acked word for a stalled decode,
    // or draining a fetch that a flush has already killed.
    typedef enum logic [1:0] {
        S_REQ  = 2'b00,
        S_HOLD = 2'b01,
        S_DROP = 2'b10
    } state_t;

    // One fetched instruction together with its return address.
    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] inst;
    } fetch_t;

    localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/if_stage_next_pc_mux.sv
// Next-PC selection. With no valid instruction in decode there is nothing
// to redirect on, so the fetch simply continues sequentially.
module next_pc_mux
    import if_stage_pkg::*;
(
    input  logic [31:0] pc4,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    input  logic [1:0]  pcsource,
    input  logic        id_valid,
    output logic [31:0] npc
);

    // 4:1 target select, overridden to pc+4 when decode holds a bubble.
    always_comb begin
        // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
        npc = pc4;
        if (id_valid) begin
            case (pcsel_t'(pcsource))
                PC_SEQ:  npc = pc4;
                PC_BR:   npc = bpc;
                PC_JR:   npc = rpc;
                PC_J:    npc = jpc;
                default: npc = pc4;
            endcase
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register. Fetches over a
// variable-latency req/ack port, parks an acked word in a one-entry hold
// buffer while decode stalls, and drains killed fetches after a flush.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] rpc,
    input  logic        id_stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] id_pc4,
    output logic [31:0] id_inst,
    output logic        id_valid
);

    state_t      state, state_nx;
    logic [31:0] pc4, npc, drop_addr;
    fetch_t      hold_q;

    // Control strobes from the FSM to the datapath registers.
    logic ifid_from_mem, ifid_from_hold, ifid_bubble;
    logic hold_load, pc_advance, drop_enter;

    assign pc4 = pc + PC_INC;

    next_pc_mux u_next_pc_mux (
        .pc4      (pc4),
        .bpc      (bpc),
        .rpc      (rpc),
        .jpc      (jpc),
        .pcsource (pcsource),
        .id_valid (id_valid),
        .npc      (npc)
    );

    // A killed fetch keeps presenting its original address until acked,
    // even though pc already points at the flush target.
    assign imem_addr = (state == S_DROP) ? drop_addr : pc;

    // FSM state register.
    always_ff @(posedge clk or posedge clrn) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (clrn) state <= S_REQ;
        else      state <= state_nx;
    end

    // Next-state and control decode; flush overrides everything else.
    always_comb begin
        state_nx       = state;
        imem_req       = 1'b0;
        ifid_from_mem  = 1'b0;
        ifid_from_hold = 1'b0;
        ifid_bubble    = 1'b0;
        hold_load      = 1'b0;
        pc_advance     = 1'b0;
        drop_enter     = 1'b0;
        case (state)
            S_REQ: begin
                imem_req = 1'b1;
                if (flush) begin
                    state_nx   = imem_ack ? S_REQ : S_DROP;
                    drop_enter = ~imem_ack;
                end else if (imem_ack) begin
                    if (id_stall) begin
                        hold_load = 1'b1;
                        state_nx  = S_HOLD;
                    end else begin
                        ifid_from_mem = 1'b1;
                        pc_advance    = 1'b1;
                    end
                end else if (!id_stall) begin
                    ifid_bubble = 1'b1;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    state_nx = S_REQ;
                end else if (!id_stall) begin
                    ifid_from_hold = 1'b1;
                    pc_advance     = 1'b1;
                    state_nx       = S_REQ;
                end
            end
            S_DROP: begin
                imem_req = 1'b1;
                if (imem_ack) state_nx = S_REQ;
            end
            default: state_nx = S_REQ;
        endcase
        // No request is presented while reset is asserted.
        if (clrn) imem_req = 1'b0;
    end

    // PC register and the frozen address of a fetch being drained.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            pc        <= RESET_PC;
            drop_addr <= RESET_PC;
        end else begin
            if (flush)           pc <= flush_pc;
            else if (pc_advance) pc <= npc;
            if (drop_enter) drop_addr <= pc;
        end
    end

    // One-entry hold buffer for a word acked while decode is stalled.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            hold_q <= '{pc4: 32'd0, inst: NOP_INST};
        end else if (flush) begin
            hold_q <= '{pc4: 32'd0, inst: NOP_INST};
        end else if (hold_load) begin
            hold_q <= '{pc4: pc4, inst: imem_rdata};
        end
    end

    // IF/ID register; an invalid entry always carries NOP_INST.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            id_valid <= 1'b0;
            id_pc4   <= 32'd0;
            id_inst  <= NOP_INST;
        end else if (flush || ifid_bubble) begin
            id_valid <= 1'b0;
            id_inst  <= NOP_INST;
        end else if (ifid_from_mem) begin
            id_valid <= 1'b1;
            id_pc4   <= pc4;
            id_inst  <= imem_rdata;
        end else if (ifid_from_hold) begin
            id_valid <= 1'b1;
            id_pc4   <= hold_q.pc4;
            id_inst  <= hold_q.inst;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a directed per-cycle vector table,
// hand-written wrap and reset sequences, then randomized traffic against
// a transaction-level reference model.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        clrn;
    logic [1:0]  pcsource;
    logic [31:0] bpc, jpc, rpc;
    logic        id_stall, flush;
    logic [31:0] flush_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc, id_pc4, id_inst;
    logic        id_valid;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Instruction memory contents: a recognisable word per address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0001;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    if_stage #(.RESET_PC(32'h0), .NOP_INST(NOP)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .jpc        (jpc),
        .rpc        (rpc),
        .id_stall   (id_stall),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .id_pc4     (id_pc4),
        .id_inst    (id_inst),
        .id_valid   (id_valid)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic        ack, stall, flush;
        logic [31:0] fpc;
        logic [1:0]  psrc;
        logic [31:0] bpc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc4;
    } vec_t;

    function automatic vec_t mk(input logic ack, input logic stall, input logic fl,
                                input logic [31:0] fpc, input logic [1:0] psrc,
                                input logic [31:0] b, input logic ereq,
                                input logic [31:0] eaddr, input logic evalid,
                                input logic [31:0] epc4);
        vec_t v;
        v.ack = ack; v.stall = stall; v.flush = fl; v.fpc = fpc; v.psrc = psrc;
        v.bpc = b; v.exp_req = ereq; v.exp_addr = eaddr; v.exp_valid = evalid;
        v.exp_pc4 = epc4;
        return v;
    endfunction

    // Reference model state: architectural view of the fetch unit.
    logic [31:0] m_pc, m_drop_addr;
    logic        m_valid;
    logic [31:0] m_pc4, m_inst;
    logic        m_discard;
    logic [63:0] m_hold[$];

    function automatic logic [31:0] model_npc(input logic [31:0] cur_pc, input logic dec_valid,
                                              input logic [1:0] sel, input logic [31:0] b,
                                              input logic [31:0] r, input logic [31:0] j);
        if (!dec_valid) return cur_pc + 32'd4;
        case (sel)
            2'd1:    return b;
            2'd2:    return r;
            2'd3:    return j;
            default: return cur_pc + 32'd4;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_drop_addr = 32'h0; m_valid = 1'b0; m_pc4 = 32'h0;
        m_inst = NOP; m_discard = 1'b0; m_hold.delete();
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        logic [31:0] nxt;
        logic [63:0] w;
        nxt = model_npc(m_pc, m_valid, pcsource, bpc, rpc, jpc);
        if (flush) begin
            if (m_hold.size() != 0) m_hold.delete();
            else if (m_discard) begin
                if (imem_ack) m_discard = 1'b0;
            end else if (!imem_ack) begin
                m_discard = 1'b1;
                m_drop_addr = m_pc;
            end
            m_valid = 1'b0; m_inst = NOP; m_pc = flush_pc;
        end else if (m_hold.size() != 0) begin
            if (!id_stall) begin
                w = m_hold.pop_front();
                m_valid = 1'b1; m_pc4 = w[63:32]; m_inst = w[31:0]; m_pc = nxt;
            end
        end else if (m_discard) begin
            if (imem_ack) m_discard = 1'b0;
        end else if (imem_ack) begin
            if (id_stall) m_hold.push_back({m_pc + 32'd4, mem_word(m_pc)});
            else begin
                m_valid = 1'b1; m_pc4 = m_pc + 32'd4; m_inst = mem_word(m_pc); m_pc = nxt;
            end
        end else if (!id_stall) begin
            m_valid = 1'b0; m_inst = NOP;
        end
    endtask

    vec_t vecs[16];

    initial begin
        logic        m_req;
        logic [31:0] m_addr;

        clrn = 1'b1; pcsource = 2'd0; bpc = '0; jpc = '0; rpc = '0;
        id_stall = 1'b0; flush = 1'b0; flush_pc = '0; imem_ack = 1'b0;

        vecs[0]  = mk(1'b1,1'b0,1'b0,32'h0,2'd0,32'h0,   1'b1,32'h004,1'b1,32'h004);
        vecs[1]  = mk(1'b1,1'b0,1'b0,32'h0,2'd0,32'h0,   1'b1,32'h008,1'b1,32'h008);
        vecs[2]  = mk(1'b1,1'b0,1'b0,32'h0,2'd0,32'h0,   1'b1,32'h00C,1'b1,32'h00C);
        vecs[3]  = mk(1'b1,1'b0,1'b0,32'h0,2'd0,32'h0,   1'b1,32'h010,1'b1,32'h010);
        vecs[4]  = mk(1'b1,1'b0,1'b0,32'h0,2'd0,32'h0,   1'b1,32'h014,1'b1,32'h014);
        vecs[5]  = mk(1'b1,1'b0,1'b0,32'h0,2'd1,32'h100, 1'b1,32'h100,1'b1,32'h018);
        vecs[6]  = mk(1'b0,1'b0,1'b0,32'h0,2'd0,32'h0,   1'b1,32'h100,1'b0,32'h0);
        vecs[7]  = mk(1'b0,1'b0,1'b0,32'h0,2'd0,32'h0,   1'b1,32'h100,1'b0,32'h0);
        vecs[8]  = mk(1'b1,1'b0,1'b0,32'h0,2'd0,32'h0,   1'b1,32'h104,1'b1,32'h104);
        vecs[9]  = mk(1'b1,1'b1,1'b0,32'h0,2'd0,32'h0,   1'b0,32'h104,1'b1,32'h104);
        vecs[10] = mk(1'b0,1'b1,1'b0,32'h0,2'd0,32'h0,   1'b0,32'h104,1'b1,32'h104);
        vecs[11] = mk(1'b0,1'b0,1'b0,32'h0,2'd0,32'h0,   1'b1,32'h108,1'b1,32'h108);
        vecs[12] = mk(1'b0,1'b0,1'b1,32'h200,2'd0,32'h0, 1'b1,32'h108,1'b0,32'h0);
        vecs[13] = mk(1'b0,1'b0,1'b0,32'h0,2'd0,32'h0,   1'b1,32'h108,1'b0,32'h0);
        vecs[14] = mk(1'b1,1'b0,1'b0,32'h0,2'd0,32'h0,   1'b1,32'h200,1'b0,32'h0);
        vecs[15] = mk(1'b1,1'b0,1'b0,32'h0,2'd0,32'h0,   1'b1,32'h204,1'b1,32'h204);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset_pc", pc, 32'h0);
        check("reset_valid", {31'd0, id_valid}, 32'd0);
        check("reset_inst", id_inst, NOP);
        check("reset_pc4", id_pc4, 32'h0);
        check("reset_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        clrn = 1'b0;
        #1;
        check("release_req", {31'd0, imem_req}, 32'd1);
        check("release_addr", imem_addr, 32'h0);

        // Directed table: sequential, branch, bubbles, stall, flush/drop.
        for (int i = 0; i < 16; i++) begin
            imem_ack = vecs[i].ack; id_stall = vecs[i].stall; flush = vecs[i].flush;
            flush_pc = vecs[i].fpc; pcsource = vecs[i].psrc; bpc = vecs[i].bpc;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].exp_req});
            check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d_valid", i), {31'd0, id_valid}, {31'd0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_pc4", i), id_pc4, vecs[i].exp_pc4);
                check($sformatf("vec%0d_inst", i), id_inst, mem_word(vecs[i].exp_pc4 - 32'd4));
            end else begin
                check($sformatf("vec%0d_inst", i), id_inst, NOP);
            end
        end

        // Wrap: flush to the top word, then fetch it sequentially.
        imem_ack = 1'b1; flush = 1'b1; flush_pc = 32'hFFFF_FFFC; pcsource = 2'd0;
        @(posedge clk);
        #1;
        check("wrap_flush_pc", pc, 32'hFFFF_FFFC);
        check("wrap_flush_valid", {31'd0, id_valid}, 32'd0);
        flush = 1'b0;
        @(posedge clk);
        #1;
        check("wrap_pc", pc, 32'h0);
        check("wrap_pc4", id_pc4, 32'h0);
        check("wrap_valid", {31'd0, id_valid}, 32'd1);
        check("wrap_inst", id_inst, mem_word(32'hFFFF_FFFC));

        // Reset pulsed while a request is outstanding.
        imem_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        clrn = 1'b1;
        #1;
        check("midreset_pc", pc, 32'h0);
        check("midreset_valid", {31'd0, id_valid}, 32'd0);
        check("midreset_req", {31'd0, imem_req}, 32'd0);
        check("midreset_inst", id_inst, NOP);
        @(negedge clk);
        clrn = 1'b0;
        model_reset();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 2000; i++) begin
            m_req = (m_hold.size() == 0);
            imem_ack = m_req ? ($urandom_range(0, 2) != 0) : 1'b0;
            id_stall = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 15) == 0);
            flush_pc = $urandom;
            pcsource = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            bpc = $urandom; jpc = $urandom; rpc = $urandom;
            model_step();
            @(posedge clk);
            #1;
            m_req  = (m_hold.size() == 0);
            m_addr = m_discard ? m_drop_addr : m_pc;
            check("rnd_req", {31'd0, imem_req}, {31'd0, m_req});
            if (m_req) check("rnd_addr", imem_addr, m_addr);
            check("rnd_pc", pc, m_pc);
            check("rnd_valid", {31'd0, id_valid}, {31'd0, m_valid});
            if (m_valid) check("rnd_pc4", id_pc4, m_pc4);
            check("rnd_inst", id_inst, m_inst);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
